// File: rtl/rx_pkg.sv
// Shared types and constants for the USB RX byte assembler.
//   rx_asm_state_t     : assembler FSM state (HUNT for SYNC, RECEIVE packet bytes)
//   SYNC_BYTE          : SYNC as it appears after LSB-first packing
//   USB_MAX_PKT_BYTES  : bytes allowed after SYNC (PID + 64 data + CRC16)
package rx_pkg;

    typedef enum logic [1:0] {
        HUNT,
        RECEIVE
    } rx_asm_state_t;

    localparam logic [7:0]  SYNC_BYTE         = 8'h80;
    localparam int unsigned USB_MAX_PKT_BYTES = 67;

endpackage

// File: rtl/rx_shift_reg8.sv
// Serial-in right-shift register, 8 bits, with enable and synchronous clear.
// New bits enter at bit 7, so the first bit shifted in ends up in bit 0.
//   clk     : system clock
//   rst     : synchronous active-high reset (clears contents)
//   clear   : synchronous clear, wins over enable
//   enable  : shift din in this cycle
//   din     : serial input bit
//   shifted : parallel out, contents with din already shifted in
//             (the value the register takes when enable is high)
module rx_shift_reg8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       din,
    output logic [7:0] shifted
);

    logic [7:0] sreg_q;

    assign shifted = {din, sreg_q[7:1]};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sreg_q <= 8'h00;
        end else if (enable) begin
            sreg_q <= shifted;
        end
    end

endmodule

// File: rtl/rx_byte_assembler.sv
// USB RX byte assembler, downstream of the bit stuff detector.
// Hunts for SYNC in a sliding window, then packs non-stuffed bits LSB-first into
// bytes and reports packet completion or framing errors on EOP.
//   clk           : system clock
//   rst           : synchronous active-high reset
//   bit_strobe    : decoded_bit / ignore_bit valid this cycle
//   decoded_bit   : NRZI-decoded bus bit
//   ignore_bit    : stuffed bit, discarded
//   eop           : end-of-packet pulse
//   rx_byte       : last completed byte, held until the next one
//   byte_valid    : pulse, rx_byte updated
//   sync_found    : pulse, SYNC matched
//   packet_active : high while receiving a packet
//   packet_done   : pulse, byte-aligned EOP without error
//   rx_error      : pulse, misaligned/empty EOP or overflow
//   byte_count    : bytes completed in the current packet
// MAX_BYTES must be <= 126 so MAX_BYTES+1 fits in byte_count.
module rx_byte_assembler
    import rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_PATTERN = SYNC_BYTE,
    parameter int unsigned MAX_BYTES    = USB_MAX_PKT_BYTES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_strobe,
    input  logic       decoded_bit,
    input  logic       ignore_bit,
    input  logic       eop,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       sync_found,
    output logic       packet_active,
    output logic       packet_done,
    output logic       rx_error,
    output logic [6:0] byte_count
);

    localparam logic [6:0] MaxCount = 7'(MAX_BYTES);

    rx_asm_state_t state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    byte_count_q, byte_count_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          byte_valid_q, byte_valid_d;
    logic          sync_found_q, sync_found_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic       accepted;
    logic       shift_en;
    logic       win_clear;
    logic [7:0] shifted;

    assign accepted = bit_strobe & ~ignore_bit;
    // EOP beats a coincident strobe while receiving: that bit is discarded.
    assign shift_en = accepted & ~((state_q == RECEIVE) & eop);
    // Start each hunt with an empty window so packet data cannot fake a SYNC.
    assign win_clear = (state_q == RECEIVE) && (state_d == HUNT);

    // One register serves as the SYNC window in HUNT and the byte packer in RECEIVE.
    rx_shift_reg8 u_shift (
        .clk     (clk),
        .rst     (rst),
        .clear   (win_clear),
        .enable  (shift_en),
        .din     (decoded_bit),
        .shifted (shifted)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_count_d = byte_count_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        sync_found_d = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (accepted && (shifted == SYNC_PATTERN)) begin
                    state_d      = RECEIVE;
                    sync_found_d = 1'b1;
                    bit_cnt_d    = 3'd0;
                    byte_count_d = 7'd0;
                end
            end
            RECEIVE: begin
                if (eop) begin
                    state_d = HUNT;
                    if ((bit_cnt_q == 3'd0) && (byte_count_q != 7'd0)) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (accepted) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_count_d = byte_count_q + 7'd1;
                        if (byte_count_q == MaxCount) begin
                            // Overflowing byte is dropped, not forwarded downstream.
                            error_d = 1'b1;
                            state_d = HUNT;
                        end else begin
                            rx_byte_d    = shifted;
                            byte_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            bit_cnt_q    <= 3'd0;
            byte_count_q <= 7'd0;
            rx_byte_q    <= 8'h00;
            byte_valid_q <= 1'b0;
            sync_found_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_count_q <= byte_count_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            sync_found_q <= sync_found_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign byte_valid    = byte_valid_q;
    assign sync_found    = sync_found_q;
    assign packet_active = (state_q == RECEIVE);
    assign packet_done   = done_q;
    assign rx_error      = error_q;
    assign byte_count    = byte_count_q;

endmodule
